// File: rtl/gf_modp_acc_if.sv
// gf_modp_acc_if: term stream and result bundle for the modular accumulator.
interface gf_modp_acc_if #(
    parameter int WIDTH = 32,
    parameter int LEN_W = 16
);
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic             i_valid;
    logic [WIDTH-1:0] i_data;
    logic             o_busy;
    logic [WIDTH-1:0] o_sum;
    logic             o_done;
    logic             o_err;
    modport master (output i_start, i_len, i_valid, i_data, input o_busy, o_sum, o_done, o_err);
    modport slave (input i_start, i_len, i_valid, i_data, output o_busy, o_sum, o_done, o_err);
endinterface

// File: rtl/gf_modp_acc.sv
// gf_modp_acc: streaming sum of a programmed number of field terms mod P, one term per clock.
module gf_modp_acc #(
    parameter int                 WIDTH = 32,
    parameter logic [WIDTH-1:0]   P     = 32'hEC940E71,
    parameter int                 LEN_W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst,
    gf_modp_acc_if.slave bus
);
    typedef enum logic {IDLE, ACC} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, sum_q, sum_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d, err_q, err_d;
    logic [WIDTH-1:0] d_red, res;
    logic [WIDTH:0]   s, r;
    // Terms may be any WIDTH-bit value; one subtraction fully reduces them since P > 2^(WIDTH-1).
    assign d_red = (bus.i_data >= P) ? bus.i_data - P : bus.i_data;
    assign s     = {1'b0, acc_q} + {1'b0, d_red};
    assign r     = (s >= {1'b0, P}) ? s - {1'b0, P} : s;
    assign res   = r[WIDTH-1:0];
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (state_q == IDLE) begin
            if (bus.i_start) begin
                err_d = 1'b0;
                if (bus.i_len == '0) begin
                    sum_d  = '0;
                    done_d = 1'b1;
                end else begin
                    acc_d   = '0;
                    cnt_d   = bus.i_len;
                    state_d = ACC;
                end
            end else if (bus.i_valid) begin
                err_d = 1'b1;
            end
        end else begin
            err_d = err_q | bus.i_start;
            if (bus.i_valid) begin
                acc_d = res;
                cnt_d = cnt_q - LEN_W'(1);
                if (cnt_q == LEN_W'(1)) begin
                    sum_d   = res;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        end
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
    assign bus.o_busy = (state_q == ACC);
    assign bus.o_sum  = sum_q;
    assign bus.o_done = done_q;
    assign bus.o_err  = err_q;
endmodule

// File: tb/tb_gf_modp_acc.sv
// tb_gf_modp_acc: directed vectors with hand-computed sums mod 0xEC940E71.
module tb_gf_modp_acc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_vec = 0;
    int   n_err = 0;
    gf_modp_acc_if #(.WIDTH(32), .LEN_W(16)) bus ();
    gf_modp_acc dut (.i_clk(clk), .i_rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic start(input logic [15:0] len);
        bus.i_start = 1'b1;
        bus.i_len   = len;
        tick();
        bus.i_start = 1'b0;
    endtask
    task automatic term(input logic [31:0] d);
        bus.i_valid = 1'b1;
        bus.i_data  = d;
        tick();
        bus.i_valid = 1'b0;
    endtask
    initial begin
        bus.i_start = 1'b0;
        bus.i_len   = '0;
        bus.i_valid = 1'b0;
        bus.i_data  = '0;
        tick();
        chk("rst_busy", 32'(bus.o_busy), 0);
        chk("rst_sum", bus.o_sum, 0);
        chk("rst_done", 32'(bus.o_done), 0);
        chk("rst_err", 32'(bus.o_err), 0);
        rst = 1'b0;
        tick();
        start(3);
        chk("basic_busy", 32'(bus.o_busy), 1);
        term(1);
        term(2);
        term(3);
        chk("basic_done", 32'(bus.o_done), 1);
        chk("basic_sum", bus.o_sum, 6);
        chk("basic_busy_low", 32'(bus.o_busy), 0);
        chk("basic_err", 32'(bus.o_err), 0);
        tick();
        chk("basic_done_pulse", 32'(bus.o_done), 0);
        start(2);
        term(32'hEC940E70);
        term(32'hEC940E70);
        chk("wrap_sum", bus.o_sum, 32'hEC940E6F);
        start(2);
        term(32'hEC940E70);
        term(1);
        chk("wrap_zero_done", 32'(bus.o_done), 1);
        chk("wrap_zero_sum", bus.o_sum, 0);
        start(1);
        term(32'hFFFFFFFF);
        chk("unred_max", bus.o_sum, 32'h136BF18E);
        start(1);
        term(32'hEC940E71);
        chk("unred_p_done", 32'(bus.o_done), 1);
        chk("unred_p", bus.o_sum, 0);
        start(1);
        term(4);
        chk("pre_zero", bus.o_sum, 4);
        start(0);
        chk("zlen_done", 32'(bus.o_done), 1);
        chk("zlen_sum", bus.o_sum, 0);
        chk("zlen_busy", 32'(bus.o_busy), 0);
        start(4);
        term(5);
        term(7);
        chk("gap_no_done", 32'(bus.o_done), 0);
        tick();
        term(11);
        repeat (3) tick();
        chk("gap_busy", 32'(bus.o_busy), 1);
        term(13);
        chk("gap_done", 32'(bus.o_done), 1);
        chk("gap_sum", bus.o_sum, 36);
        term(99);
        chk("stray_err", 32'(bus.o_err), 1);
        chk("stray_sum", bus.o_sum, 36);
        chk("stray_done", 32'(bus.o_done), 0);
        bus.i_valid = 1'b1;
        bus.i_data  = 32'd50;
        start(1);
        bus.i_valid = 1'b0;
        chk("start_valid_err", 32'(bus.o_err), 0);
        chk("start_valid_busy", 32'(bus.o_busy), 1);
        term(3);
        chk("start_valid_sum", bus.o_sum, 3);
        start(2);
        term(1);
        bus.i_start = 1'b1;
        bus.i_len   = 16'd7;
        term(1);
        bus.i_start = 1'b0;
        chk("acc_start_done", 32'(bus.o_done), 1);
        chk("acc_start_sum", bus.o_sum, 2);
        chk("acc_start_err", 32'(bus.o_err), 1);
        chk("acc_start_idle", 32'(bus.o_busy), 0);
        start(1);
        chk("err_clear", 32'(bus.o_err), 0);
        term(8);
        chk("err_clear_sum", bus.o_sum, 8);
        start(5);
        term(1);
        term(2);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.o_busy), 0);
        chk("arst_sum", bus.o_sum, 0);
        chk("arst_done", 32'(bus.o_done), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("arst_no_done", 32'(bus.o_done), 0);
        end
        start(1);
        term(9);
        chk("post_rst_done", 32'(bus.o_done), 1);
        chk("post_rst_sum", bus.o_sum, 9);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
